// File: rtl/panel_fb_arbiter_if.sv
// Bus between the frame-buffer arbiter, the panel scanner and the host pixel writer.
// Coordinate fields carry one bit beyond clog2 so out-of-range positions can be presented.
interface panel_fb_arbiter_if #(
    parameter int COLOR_DEPTH = 1,
    parameter int ROWS        = 16,
    parameter int COLS        = 32
);
    localparam int PW = 3 * COLOR_DEPTH;
    localparam int RW = $clog2(ROWS) + 1;
    localparam int CW = $clog2(COLS) + 1;

    logic          i_rd_req;
    logic [RW-1:0] i_rd_row;
    logic [CW-1:0] i_rd_col;
    logic          o_rd_gnt;
    logic          o_rd_valid;
    logic [PW-1:0] o_rd_data;
    logic          i_frame_end;
    logic          i_wr_valid;
    logic [CW-1:0] i_wr_x;
    logic [RW-1:0] i_wr_y;
    logic [PW-1:0] i_wr_rgb;
    logic          o_wr_ready;
    logic          o_wr_err;
    logic          i_swap_req;
    logic          o_swap_done;
    logic          o_display_bank;

    modport slave (
        input  i_rd_req, i_rd_row, i_rd_col, i_frame_end,
        input  i_wr_valid, i_wr_x, i_wr_y, i_wr_rgb, i_swap_req,
        output o_rd_gnt, o_rd_valid, o_rd_data, o_wr_ready, o_wr_err,
        output o_swap_done, o_display_bank
    );

    modport master (
        output i_rd_req, i_rd_row, i_rd_col, i_frame_end,
        output i_wr_valid, i_wr_x, i_wr_y, i_wr_rgb, i_swap_req,
        input  o_rd_gnt, o_rd_valid, o_rd_data, o_wr_ready, o_wr_err,
        input  o_swap_done, o_display_bank
    );
endinterface

// File: rtl/panel_fb_arbiter.sv
// Double-buffered LED panel frame buffer: scanner reads the display bank, host fills the
// draw bank, and bank swaps are deferred to a scanner frame boundary.
module panel_fb_arbiter #(
    parameter int COLOR_DEPTH = 1,
    parameter int ROWS        = 16,
    parameter int COLS        = 32
) (
    input  logic                i_clock,
    input  logic                i_reset,
    panel_fb_arbiter_if.slave   bus
);
    localparam int PW        = 3 * COLOR_DEPTH;
    localparam int RB        = $clog2(ROWS);
    localparam int CB        = $clog2(COLS);
    localparam int RW        = RB + 1;
    localparam int CW        = CB + 1;
    localparam int AW        = 1 + RB + CB;
    localparam int MEM_DEPTH = 1 << AW;
    localparam logic [RW-1:0] ROW_LIM = RW'(ROWS);
    localparam logic [CW-1:0] COL_LIM = CW'(COLS);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } swap_state_t;

    swap_state_t   r_state;
    swap_state_t   w_state_next;
    logic          r_display_bank;
    logic [1:0]    r_starve_cnt;
    logic          r_rd_valid;
    logic [PW-1:0] r_rd_data;
    logic          r_wr_err;
    logic          r_swap_done;
    logic [PW-1:0] r_mem [0:MEM_DEPTH-1];

    logic          w_swap_pending;
    logic          w_wr_ready;
    logic          w_rd_gnt;
    logic          w_wr_fire;
    logic          w_flip;
    logic          w_rd_oob;
    logic          w_wr_oob;
    logic [AW-1:0] w_rd_addr;
    logic [AW-1:0] w_wr_addr;

    assign w_swap_pending = (r_state == ST_PENDING);
    // The host wins only once the scanner has beaten it three times in a row.
    assign w_wr_ready     = !w_swap_pending && (!bus.i_rd_req || (r_starve_cnt == 2'd3));
    assign w_rd_gnt       = bus.i_rd_req && !(w_wr_ready && bus.i_wr_valid);
    assign w_wr_fire      = bus.i_wr_valid && w_wr_ready;
    assign w_rd_oob       = (bus.i_rd_row >= ROW_LIM) || (bus.i_rd_col >= COL_LIM);
    assign w_wr_oob       = (bus.i_wr_y >= ROW_LIM) || (bus.i_wr_x >= COL_LIM);
    assign w_rd_addr      = {r_display_bank, bus.i_rd_row[RB-1:0], bus.i_rd_col[CB-1:0]};
    assign w_wr_addr      = {~r_display_bank, bus.i_wr_y[RB-1:0], bus.i_wr_x[CB-1:0]};

    assign bus.o_rd_gnt       = w_rd_gnt;
    assign bus.o_wr_ready     = w_wr_ready;
    assign bus.o_rd_valid     = r_rd_valid;
    assign bus.o_rd_data      = r_rd_data;
    assign bus.o_wr_err       = r_wr_err;
    assign bus.o_swap_done    = r_swap_done;
    assign bus.o_display_bank = r_display_bank;

    // Swap scheduler next state: a request with frame_end in the same cycle flips at once.
    always_comb begin
        w_state_next = r_state;
        w_flip       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_swap_req && bus.i_frame_end) begin
                    w_flip = 1'b1;
                end else if (bus.i_swap_req) begin
                    w_state_next = ST_PENDING;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (bus.i_frame_end) begin
                    w_flip       = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_PENDING;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Swap state, display bank and done pulse.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_display_bank <= 1'b0;
            r_swap_done    <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_display_bank <= r_display_bank ^ w_flip;
            r_swap_done    <= w_flip;
        end
    end

    // Host starvation counter and out-of-range write flag.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_starve_cnt <= 2'd0;
            r_wr_err     <= 1'b0;
        end else begin
            r_wr_err <= w_wr_fire && w_wr_oob;
            if (w_wr_fire) begin
                r_starve_cnt <= 2'd0;
            end else if (bus.i_wr_valid && !w_swap_pending && w_rd_gnt
                         && (r_starve_cnt != 2'd3)) begin
                r_starve_cnt <= r_starve_cnt + 2'd1;
            end
        end
    end

    // Scanner read port; data holds until the next grant.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= {PW{1'b0}};
        end else begin
            r_rd_valid <= w_rd_gnt;
            if (w_rd_gnt) begin
                r_rd_data <= w_rd_oob ? {PW{1'b0}} : r_mem[w_rd_addr];
            end
        end
    end

    // Pixel memory is deliberately not reset so frames survive a controller reset.
    always_ff @(posedge i_clock) begin
        if (w_wr_fire && !w_wr_oob) begin
            r_mem[w_wr_addr] <= bus.i_wr_rgb;
        end
    end
endmodule

// File: tb/tb_panel_fb_arbiter.sv
// Self-checking bench for panel_fb_arbiter: directed tables and sequences plus random
// traffic compared every cycle against an array-based frame-buffer model.
module tb_panel_fb_arbiter;
    localparam int CD   = 1;
    localparam int ROWS = 16;
    localparam int COLS = 32;
    localparam int PW   = 3 * CD;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    panel_fb_arbiter_if #(.COLOR_DEPTH(CD), .ROWS(ROWS), .COLS(COLS)) bus ();
    panel_fb_arbiter #(.COLOR_DEPTH(CD), .ROWS(ROWS), .COLS(COLS)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: two banks of pixels with a known-flag per pixel, plus swap/arbitration state.
    logic [PW-1:0] m_mem   [0:1][0:ROWS-1][0:COLS-1];
    bit            m_known [0:1][0:ROWS-1][0:COLS-1];
    int            m_bank, m_lost;
    bit            m_pending, m_rd_valid, m_rd_known, m_err, m_done;
    logic [PW-1:0] m_rd_data;

    typedef struct {
        logic rd_req;
        logic wr_valid;
        logic exp_gnt;
        logic exp_ready;
    } arb_vec_t;
    arb_vec_t arb_tab [0:6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic set_idle();
        bus.i_rd_req = 1'b0; bus.i_rd_row = '0; bus.i_rd_col = '0;
        bus.i_frame_end = 1'b0; bus.i_wr_valid = 1'b0; bus.i_wr_x = '0;
        bus.i_wr_y = '0; bus.i_wr_rgb = '0; bus.i_swap_req = 1'b0;
    endtask

    task automatic model_reset();
        m_bank = 0; m_lost = 0; m_pending = 0;
        m_rd_valid = 0; m_rd_known = 1; m_rd_data = '0; m_err = 0; m_done = 0;
    endtask

    function automatic bit model_ready();
        return !m_pending && (!bus.i_rd_req || m_lost == 3);
    endfunction

    function automatic bit model_gnt();
        return bus.i_rd_req && !(model_ready() && bus.i_wr_valid);
    endfunction

    task automatic model_edge();
        bit ready, gnt, flip;
        int r, c, y, x;
        ready = model_ready();
        gnt   = model_gnt();
        r = int'(bus.i_rd_row); c = int'(bus.i_rd_col);
        y = int'(bus.i_wr_y);   x = int'(bus.i_wr_x);
        m_rd_valid = gnt;
        if (gnt) begin
            if (r >= ROWS || c >= COLS) begin
                m_rd_data = '0; m_rd_known = 1;
            end else begin
                m_rd_data = m_mem[m_bank][r][c]; m_rd_known = m_known[m_bank][r][c];
            end
        end
        if (bus.i_wr_valid && ready) begin
            m_lost = 0;
            m_err  = (y >= ROWS || x >= COLS);
            if (!m_err) begin
                m_mem[1-m_bank][y][x]   = bus.i_wr_rgb;
                m_known[1-m_bank][y][x] = 1;
            end
        end else begin
            m_err = 0;
            if (bus.i_wr_valid && !m_pending && gnt && m_lost < 3) m_lost++;
        end
        flip   = (m_pending || bus.i_swap_req) && bus.i_frame_end;
        m_done = flip;
        if (flip) begin
            m_bank    = 1 - m_bank;
            m_pending = 0;
        end else if (bus.i_swap_req) begin
            m_pending = 1;
        end
    endtask

    // One clock: compare every output against the model mid-cycle, then advance the model.
    task automatic tick();
        #4;
        chk("wr_ready", bus.o_wr_ready, model_ready());
        chk("rd_gnt", bus.o_rd_gnt, model_gnt());
        chk("rd_valid", bus.o_rd_valid, m_rd_valid);
        chk("wr_err", bus.o_wr_err, m_err);
        chk("swap_done", bus.o_swap_done, m_done);
        chk("display_bank", bus.o_display_bank, m_bank);
        if (m_rd_known) chk("rd_data", bus.o_rd_data, m_rd_data);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_write(input int y, input int x, input int rgb);
        set_idle();
        bus.i_wr_valid = 1'b1; bus.i_wr_y = 5'(y); bus.i_wr_x = 6'(x); bus.i_wr_rgb = 3'(rgb);
        tick();
        set_idle();
    endtask

    task automatic do_read(input int y, input int x);
        set_idle();
        bus.i_rd_req = 1'b1; bus.i_rd_row = 5'(y); bus.i_rd_col = 6'(x);
        tick();
        set_idle();
    endtask

    task automatic do_swap_now();
        set_idle();
        bus.i_swap_req = 1'b1; bus.i_frame_end = 1'b1;
        tick();
        set_idle();
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) m_known[b][r][c] = 0;
        arb_tab[0] = '{1'b1, 1'b1, 1'b1, 1'b0};
        arb_tab[1] = '{1'b1, 1'b1, 1'b1, 1'b0};
        arb_tab[2] = '{1'b1, 1'b1, 1'b1, 1'b0};
        arb_tab[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
        arb_tab[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        arb_tab[5] = '{1'b0, 1'b1, 1'b0, 1'b1};
        arb_tab[6] = '{1'b1, 1'b0, 1'b1, 1'b0};

        set_idle();
        model_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_rd_valid", bus.o_rd_valid, 1'b0);
        chk("reset_rd_data", bus.o_rd_data, 3'b000);
        chk("reset_bank", bus.o_display_bank, 1'b0);
        chk("reset_wr_ready", bus.o_wr_ready, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Write to bank 1, swap on a frame boundary, read it back from the display.
        do_write(2, 3, 5);
        set_idle(); bus.i_swap_req = 1'b1; tick();
        set_idle(); bus.i_frame_end = 1'b1; tick();
        set_idle();
        chk("t1_swap_done", bus.o_swap_done, 1'b1);
        chk("t1_bank", bus.o_display_bank, 1'b1);
        do_read(2, 3);
        chk("t1_swap_done_once", bus.o_swap_done, 1'b0);
        chk("t1_rd_valid", bus.o_rd_valid, 1'b1);
        chk("t1_rd_data", bus.o_rd_data, 3'b101);

        // Arbitration table: scanner priority with host anti-starvation.
        for (int i = 0; i < 7; i++) begin
            set_idle();
            bus.i_rd_req = arb_tab[i].rd_req; bus.i_wr_valid = arb_tab[i].wr_valid;
            bus.i_wr_x = 6'd1; bus.i_wr_y = 5'd1; bus.i_wr_rgb = 3'b010;
            #1;
            chk($sformatf("arb_gnt[%0d]", i), bus.o_rd_gnt, arb_tab[i].exp_gnt);
            chk($sformatf("arb_ready[%0d]", i), bus.o_wr_ready, arb_tab[i].exp_ready);
            tick();
        end
        set_idle();

        // Deferred swap: writes stall from the request until the frame boundary.
        set_idle(); bus.i_swap_req = 1'b1; tick();
        for (int i = 0; i < 15; i++) begin
            set_idle(); bus.i_wr_valid = 1'b1; bus.i_wr_x = 6'd4; bus.i_wr_y = 5'd4;
            bus.i_wr_rgb = 3'b011; bus.i_frame_end = (i == 14);
            #1;
            chk($sformatf("t3_stall[%0d]", i), bus.o_wr_ready, 1'b0);
            tick();
        end
        set_idle(); bus.i_wr_valid = 1'b1; bus.i_wr_x = 6'd4; bus.i_wr_y = 5'd4;
        bus.i_wr_rgb = 3'b011;
        #1;
        chk("t3_done", bus.o_swap_done, 1'b1);
        chk("t3_bank", bus.o_display_bank, 1'b0);
        chk("t3_ready_after", bus.o_wr_ready, 1'b1);
        tick();
        set_idle();

        // Immediate swap, then a duplicate request that must flip only once.
        do_swap_now();
        chk("t4_imm_done", bus.o_swap_done, 1'b1);
        chk("t4_imm_bank", bus.o_display_bank, 1'b1);
        set_idle(); bus.i_swap_req = 1'b1; tick();
        set_idle(); bus.i_swap_req = 1'b1; tick();
        set_idle(); bus.i_frame_end = 1'b1; tick();
        set_idle(); bus.i_frame_end = 1'b1; tick();
        set_idle();
        chk("t4_one_flip_bank", bus.o_display_bank, 1'b0);
        chk("t4_no_second_done", bus.o_swap_done, 1'b0);

        // Out-of-range write and read.
        do_write(1, 40, 7);
        chk("t5_wr_err", bus.o_wr_err, 1'b1);
        tick();
        chk("t5_wr_err_pulse", bus.o_wr_err, 1'b0);
        do_swap_now();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) do_read(r, c);
        tick();
        do_read(20, 3);
        chk("t5_oob_valid", bus.o_rd_valid, 1'b1);
        chk("t5_oob_data", bus.o_rd_data, 3'b000);

        // Reset during a pending swap with a read in flight; memory must survive.
        if (m_bank == 0) do_swap_now();
        do_write(7, 9, 6);
        set_idle(); bus.i_swap_req = 1'b1; tick();
        do_read(7, 9);
        #2 rst = 1'b1;
        #1;
        chk("t6_rd_valid", bus.o_rd_valid, 1'b0);
        chk("t6_rd_data", bus.o_rd_data, 3'b000);
        chk("t6_wr_err", bus.o_wr_err, 1'b0);
        chk("t6_bank", bus.o_display_bank, 1'b0);
        model_reset();
        set_idle(); bus.i_frame_end = 1'b1;
        @(posedge clk); #1;
        chk("t6_no_done", bus.o_swap_done, 1'b0);
        rst = 1'b0;
        set_idle(); bus.i_frame_end = 1'b1; tick();
        chk("t6_pending_cleared", bus.o_swap_done, 1'b0);
        do_read(7, 9);
        chk("t6_mem_kept", bus.o_rd_data, 3'b110);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.i_rd_req    = ($urandom_range(0, 1) == 1);
            bus.i_rd_row    = 5'($urandom_range(0, 17));
            bus.i_rd_col    = 6'($urandom_range(0, 34));
            bus.i_wr_valid  = ($urandom_range(0, 1) == 1);
            bus.i_wr_y      = 5'($urandom_range(0, 17));
            bus.i_wr_x      = 6'($urandom_range(0, 34));
            bus.i_wr_rgb    = 3'($urandom_range(0, 7));
            bus.i_swap_req  = ($urandom_range(0, 19) == 0);
            bus.i_frame_end = ($urandom_range(0, 9) == 0);
            tick();
        end
        set_idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
